// File: rtl/dmem_wait_responder_if.sv
// Request/response bundle between a load/store unit and its data-memory responder.
// Master drives Req/We/Addr/Wdata; slave answers with Rdata/Ready/Err/Busy, no queueing.
interface dmem_wait_responder_if;
    logic        Req;
    logic        We;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        Ready;
    logic        Err;
    logic        Busy;

    modport master (
        output Req, We, Addr, Wdata,
        input  Rdata, Ready, Err, Busy
    );

    modport slave (
        input  Req, We, Addr, Wdata,
        output Rdata, Ready, Err, Busy
    );
endinterface

// File: rtl/dmem_wait_responder.sv
// Multi-cycle word data-memory responder for a stalling load/store unit.
// Ready pulses LATENCY cycles after the accepting edge; Req is ignored, not queued, while Busy.
module dmem_wait_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic                 Clk,
    input  logic                 Clrn,
    dmem_wait_responder_if.slave bus
);
    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic                    req_we;
    logic                    req_err;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [31:0]             req_wdata;
    logic [31:0]             rdata_q;
    logic [31:0]             mem [WORDS];

    logic                    in_err;
    logic                    accept;
    logic                    commit;
    logic                    cur_we;
    logic                    cur_err;
    logic [DEPTH_LOG2-1:0]   cur_idx;
    logic [31:0]             cur_wdata;

    assign in_err = (|bus.Addr[1:0]) | (|bus.Addr[31:DEPTH_LOG2+2]);

    always_ff @(posedge Clk) begin
        if (Clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.Req) begin
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is the accept edge, so the live inputs
    // stand in for the request registers that are only being loaded then.
    always_comb begin
        accept    = (state == IDLE) && bus.Req;
        commit    = (state_nxt == RESP) && (state != RESP);
        cur_we    = req_we;
        cur_err   = req_err;
        cur_idx   = req_idx;
        cur_wdata = req_wdata;
        if (state == IDLE) begin
            cur_we    = bus.We;
            cur_err   = in_err;
            cur_idx   = bus.Addr[DEPTH_LOG2+1:2];
            cur_wdata = bus.Wdata;
        end
    end

    assign bus.Ready = (state == RESP);
    assign bus.Err   = (state == RESP) & req_err;
    assign bus.Busy  = (state != IDLE);
    assign bus.Rdata = rdata_q;

    always_ff @(posedge Clk) begin
        if (Clrn) begin
            cnt       <= 4'd0;
            req_we    <= 1'b0;
            req_err   <= 1'b0;
            req_idx   <= '0;
            req_wdata <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            if (accept) begin
                cnt       <= CNT_INIT;
                req_we    <= bus.We;
                req_err   <= in_err;
                req_idx   <= bus.Addr[DEPTH_LOG2+1:2];
                req_wdata <= bus.Wdata;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                if (cur_err) begin
                    rdata_q <= 32'd0;
                end else if (cur_we) begin
                    rdata_q <= cur_wdata;
                end else begin
                    rdata_q <= mem[cur_idx];
                end
            end
        end
    end

    // Storage deliberately has no reset; contents survive Clrn.
    always_ff @(posedge Clk) begin
        if (!Clrn && commit && cur_we && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: one LATENCY=2 and one LATENCY=1 instance
// driven by directed and random traffic against an edge-numbered transaction model.
module tb_dmem_wait_responder;
    localparam int DL    = 6;
    localparam int WORDS = 1 << DL;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    logic Clk = 1'b0;
    logic clrn0;
    logic clrn1;
    always #5 Clk = ~Clk;

    dmem_wait_responder_if if0();
    dmem_wait_responder_if if1();

    dmem_wait_responder #(.DEPTH_LOG2(DL), .LATENCY(2)) u_dut0 (
        .Clk (Clk),
        .Clrn(clrn0),
        .bus (if0.slave)
    );

    dmem_wait_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) u_dut1 (
        .Clk (Clk),
        .Clrn(clrn1),
        .bus (if1.slave)
    );

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int lat [2] = '{2, 1};

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem   [2][WORDS];
    bit          known [2][WORDS];
    int          free_at [2];
    int          busy_lo [2];
    int          busy_hi [2];
    int          en_edge [2];
    int          rst_edge[2];
    bit          pend_vld [2];
    int          pend_edge[2];
    bit          pend_wr  [2];
    int          pend_idx [2];
    logic [31:0] pend_old [2];
    bit          pend_oldk[2];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model of one transaction decision for the upcoming edge (cyc+1); then drive pins.
    task automatic apply(int d, bit rst, bit req, bit we, logic [31:0] addr, logic [31:0] wdata);
        int   ne;
        int   idx;
        bit   err;
        exp_t e;
        ne = cyc + 1;
        if (rst) begin
            if (pend_vld[d] && pend_edge[d] >= ne) begin
                if (pend_wr[d]) begin
                    mem[d][pend_idx[d]]   = pend_old[d];
                    known[d][pend_idx[d]] = pend_oldk[d];
                end
                if (d == 0) q0.delete(q0.size() - 1);
                else        q1.delete(q1.size() - 1);
            end
            pend_vld[d] = 1'b0;
            if (busy_hi[d] >= ne) busy_hi[d] = ne - 1;
            free_at[d]  = ne + 1;
            rst_edge[d] = ne;
            if (en_edge[d] > ne) en_edge[d] = ne;
        end else if (req && ne >= free_at[d]) begin
            idx     = int'(addr[DL+1:2]);
            err     = (addr[1:0] != 2'b00) || ((addr >> (DL + 2)) != 32'd0);
            e.cyc   = ne + lat[d] - 1;
            e.err   = err;
            e.chk   = err || we || known[d][idx];
            e.rdata = err ? 32'd0 : (we ? wdata : mem[d][idx]);
            pend_vld[d]  = 1'b1;
            pend_edge[d] = e.cyc;
            pend_wr[d]   = we && !err;
            pend_idx[d]  = idx;
            pend_old[d]  = mem[d][idx];
            pend_oldk[d] = known[d][idx];
            if (we && !err) begin
                mem[d][idx]   = wdata;
                known[d][idx] = 1'b1;
            end
            busy_lo[d] = ne;
            busy_hi[d] = e.cyc;
            free_at[d] = ne + lat[d] + 1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (d == 0) begin
            clrn0 = rst; if0.Req = req; if0.We = we; if0.Addr = addr; if0.Wdata = wdata;
        end else begin
            clrn1 = rst; if1.Req = req; if1.We = we; if1.Addr = addr; if1.Wdata = wdata;
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic op(int d, bit we, logic [31:0] addr, logic [31:0] wdata);
        apply(d, 1'b0, 1'b1, we, addr, wdata);
        tick(1);
        apply(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(lat[d] + 1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        a = {24'd0, 6'($urandom_range(0, WORDS - 1)), 2'b00};
        if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
        if (r == 1) a = a | (32'h100 << $urandom_range(0, 23));
        return a;
    endfunction

    task automatic mon(int d);
        logic        rdy;
        logic        err;
        logic        busy;
        logic [31:0] rdata;
        bit          exp_busy;
        exp_t        e;
        string       tag;
        if (d == 0) begin
            rdy = if0.Ready; err = if0.Err; busy = if0.Busy; rdata = if0.Rdata;
        end else begin
            rdy = if1.Ready; err = if1.Err; busy = if1.Busy; rdata = if1.Rdata;
        end
        if (cyc < en_edge[d]) return;
        tag = $sformatf("d%0d", d);
        exp_busy = (cyc >= busy_lo[d]) && (cyc <= busy_hi[d]);
        check({tag, " busy"}, 32'(busy), 32'(exp_busy));
        if (cyc == rst_edge[d]) begin
            check({tag, " reset ready"}, 32'(rdy), 32'd0);
            check({tag, " reset rdata"}, rdata, 32'd0);
        end
        if (rdy) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                vectors++;
                miscompares++;
                $display("FAIL %s spurious ready: got ready=1 expected no response (cycle %0d)", tag, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check({tag, " ready cycle"}, 32'(cyc), 32'(e.cyc));
                check({tag, " err"}, 32'(err), 32'(e.err));
                if (e.chk) check({tag, " rdata"}, rdata, e.rdata);
            end
        end else begin
            check({tag, " err idle"}, 32'(err), 32'd0);
            if (d == 0 && q0.size() != 0 && q0[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL d0 missing ready: got ready=0 expected ready=1 (cycle %0d)", cyc);
                void'(q0.pop_front());
            end
            if (d == 1 && q1.size() != 0 && q1[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL d1 missing ready: got ready=0 expected ready=1 (cycle %0d)", cyc);
                void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0; busy_lo[d] = 0; busy_hi[d] = -1;
            en_edge[d] = 1 << 30; rst_edge[d] = -1; pend_vld[d] = 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                known[d][i] = 1'b0;
                mem[d][i]   = 32'd0;
            end
        end
        apply(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        apply(1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(1);
        apply(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        apply(1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(1);
        apply(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        apply(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(2);

        // LATENCY=2 directed sequence
        op(0, 1'b0, 32'h0000_0014, 32'd0);
        op(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        op(0, 1'b0, 32'h0000_0010, 32'd0);
        op(0, 1'b1, 32'h0000_0012, 32'h0000_0001);
        op(0, 1'b0, 32'h0000_0010, 32'd0);
        op(0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D);
        op(0, 1'b1, 32'h0000_0100, 32'h1234_5678);
        op(0, 1'b0, 32'h0000_0000, 32'd0);
        op(0, 1'b1, 32'h0000_0004, 32'hA5A5_0004);
        for (int i = 0; i < 10; i++) begin
            apply(0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'($urandom));
            tick(1);
        end
        apply(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(4);
        op(0, 1'b1, 32'h0000_0020, 32'h1111_2222);
        apply(0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA);
        tick(1);
        apply(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(1);
        apply(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(2);
        op(0, 1'b0, 32'h0000_0020, 32'd0);

        // Random traffic, inputs wiggle freely during WAIT
        for (int i = 0; i < 300; i++) begin
            apply(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                  1'($urandom), rand_addr(), 32'($urandom));
            tick(1);
        end
        apply(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(4);

        // LATENCY=1 instance
        op(1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D);
        op(1, 1'b0, 32'h0000_0008, 32'd0);
        for (int i = 0; i < 6; i++) begin
            apply(1, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'd0);
            tick(1);
        end
        apply(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(3);
        for (int i = 0; i < 200; i++) begin
            apply(1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                  1'($urandom), rand_addr(), 32'($urandom));
            tick(1);
        end
        apply(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(5);

        check("d0 leftover expectations", 32'(q0.size()), 32'd0);
        check("d1 leftover expectations", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
